// File: rtl/regfile_wb_if.sv
// Writeback request/grant bundle between the requesters and the shared
// register-file write port, including the registered write-port outputs.
interface regfile_wb_if #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    hold;
   logic                    rf_we;
   logic [ADDR_W-1:0]       rf_waddr;
   logic [DATA_W-1:0]       rf_wdata;
   logic [1:0]              grant_id;
   logic                    busy;

   modport master (
      output req_valid, req_addr, req_data, hold,
      input  req_ready, rf_we, rf_waddr, rf_wdata, grant_id, busy
   );

   modport slave (
      input  req_valid, req_addr, req_data, hold,
      output req_ready, rf_we, rf_waddr, rf_wdata, grant_id, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Fixed-priority writeback arbiter with starvation override and a registered
// register-file write stage. Optional write-forwarding ports under RF_WB_FWD_EN.
module regfile_wb_arbiter #(
   parameter int N_REQ    = 2,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int MAX_WAIT = 4
) (
   input logic               clk,
   input logic               rst,
   regfile_wb_if.slave       bus
`ifdef RF_WB_FWD_EN
   ,
   input  logic [ADDR_W-1:0] fwd_raddr1,
   input  logic [ADDR_W-1:0] fwd_raddr2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2
`endif
);

   localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

   logic [N_REQ-1:0]  grantOh;
   logic [1:0]        grantIdx;
   logic              starveFound;
   logic              baseFound;
   logic              xfer;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selData;

   logic [3:0]        waitCnt_q [N_REQ];
   logic [3:0]        waitCnt_d [N_REQ];

   logic              rfWe_q;
   logic [ADDR_W-1:0] rfWaddr_q;
   logic [DATA_W-1:0] rfWdata_q;
   logic [1:0]        grantId_q;

   // A starved requester (lowest index first) beats the base fixed priority.
   always_comb begin
      grantOh     = '0;
      grantIdx    = '0;
      starveFound = 1'b0;
      baseFound   = 1'b0;
      if (!bus.hold && !rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!starveFound && bus.req_valid[i] && (waitCnt_q[i] >= MaxWaitC)) begin
               starveFound = 1'b1;
               grantIdx    = 2'(i);
            end
         end
         if (!starveFound) begin
            for (int i = 0; i < N_REQ; i++) begin
               if (!baseFound && bus.req_valid[i]) begin
                  baseFound = 1'b1;
                  grantIdx  = 2'(i);
               end
            end
         end
         if (starveFound || baseFound) begin
            grantOh[grantIdx] = 1'b1;
         end
      end
   end

   assign xfer    = |(bus.req_valid & grantOh);
   assign selAddr = bus.req_addr[int'(grantIdx)*ADDR_W +: ADDR_W];
   assign selData = bus.req_data[int'(grantIdx)*DATA_W +: DATA_W];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         waitCnt_d[i] = waitCnt_q[i];
         if (!bus.hold) begin
            if (!bus.req_valid[i] || grantOh[i]) begin
               waitCnt_d[i] = 4'd0;
            end else if (waitCnt_q[i] != 4'hF) begin
               waitCnt_d[i] = waitCnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            waitCnt_q[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            waitCnt_q[i] <= waitCnt_d[i];
         end
      end
   end

   // Writes to x0 still complete the handshake but never assert the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         rfWe_q    <= 1'b0;
         rfWaddr_q <= '0;
         rfWdata_q <= '0;
         grantId_q <= '0;
      end else if (xfer) begin
         rfWe_q    <= (selAddr != '0);
         rfWaddr_q <= selAddr;
         rfWdata_q <= selData;
         grantId_q <= grantIdx;
      end else begin
         rfWe_q    <= 1'b0;
      end
   end

   assign bus.req_ready = grantOh;
   assign bus.rf_we     = rfWe_q;
   assign bus.rf_waddr  = rfWaddr_q;
   assign bus.rf_wdata  = rfWdata_q;
   assign bus.grant_id  = grantId_q;
   assign bus.busy      = (|bus.req_valid) & ~bus.hold;

`ifdef RF_WB_FWD_EN
   assign fwd_hit1  = rfWe_q && (rfWaddr_q == fwd_raddr1) && (fwd_raddr1 != '0);
   assign fwd_hit2  = rfWe_q && (rfWaddr_q == fwd_raddr2) && (fwd_raddr2 != '0);
   assign fwd_data1 = fwd_hit1 ? rfWdata_q : '0;
   assign fwd_data2 = fwd_hit2 ? rfWdata_q : '0;
`endif

endmodule
